// File: rtl/qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module      : qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell
// Description : Multi-cycle 32-bit integer divider for the Nios II execute
//               stage. Uses restoring division, one quotient bit per clock.
//               It supports signed (div/rem) and unsigned (divu/remu)
//               operation and returns either the quotient or the remainder.
//
// Ports       : clk           rising-edge clock
//               reset_n       asynchronous active-low reset
//               E_src1        dividend (sampled on an accepted start)
//               E_src2        divisor  (sampled on an accepted start)
//               E_div_start   start pulse; honoured only while idle
//               E_div_signed  1 = two's-complement, 0 = unsigned
//               E_div_rem     1 = return remainder, 0 = return quotient
//               M_div_busy    high while an operation is in flight
//               M_div_done    one-cycle result-valid pulse
//               M_div_result  selected result; held until the next done
//
// Options     : QSYS_NIOS2_DDR3_CPU_DIV_EARLY_OUT_EN
//               When defined, operations with a zero divisor or with
//               |dividend| < |divisor| skip the iteration phase. The result
//               values are the same in both builds; only latency changes.
//
// Revision    : 1.0  initial release
// ============================================================================
module qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              E_div_rem,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;

  // Partial remainder and the shifting dividend/quotient register pair.
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;   // divisor magnitude
  logic [DATA_W-1:0] dividend;  // raw dividend, used for the divide-by-zero remainder
  logic              quo_neg;   // final quotient must be negated
  logic              rem_neg;   // final remainder must be negated
  logic              rem_sel;   // return remainder instead of quotient
  logic              div_zero;  // divisor was zero
  logic [4:0]        count;     // steps remaining minus one

  // --------------------------------------------------------------------------
  // Operand conditioning (applies only in IDLE, when the operands are loaded)
  // --------------------------------------------------------------------------
  logic              src1_neg;
  logic              src2_neg;
  logic [DATA_W-1:0] src1_mag;
  logic [DATA_W-1:0] src2_mag;
  logic              early_out;

  assign src1_neg = E_div_signed & E_src1[DATA_W-1];
  assign src2_neg = E_div_signed & E_src2[DATA_W-1];
  // Negating 0x80000000 wraps to itself, which is the correct unsigned
  // magnitude, so the most negative value needs no special handling.
  assign src1_mag = src1_neg ? (~E_src1 + 1'b1) : E_src1;
  assign src2_mag = src2_neg ? (~E_src2 + 1'b1) : E_src2;

`ifdef QSYS_NIOS2_DDR3_CPU_DIV_EARLY_OUT_EN
  // With zero quotient the remainder is just the dividend, so these cases
  // can go straight to sign fix-up.
  assign early_out = (src2_mag == '0) || (src1_mag < src2_mag);
`else
  assign early_out = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One restoring-division step
  // --------------------------------------------------------------------------
  logic [DATA_W:0]   partial;     // {rem, next dividend bit}, 33 bits
  logic [DATA_W:0]   trial;       // 33-bit trial difference
  logic              trial_ok;
  logic [DATA_W-1:0] rem_step;
  logic [DATA_W-1:0] quo_step;

  assign partial  = {rem, quo[DATA_W-1]};
  assign trial    = partial - {1'b0, divisor};
  // A set partial MSB means partial >= 2^32 > divisor, so the subtraction
  // cannot go negative even though trial[32] may read back as 1.
  assign trial_ok = partial[DATA_W] | ~trial[DATA_W];
  // Whichever branch is kept is below the divisor, so 32 bits suffice.
  assign rem_step = trial_ok ? trial[DATA_W-1:0] : partial[DATA_W-1:0];
  assign quo_step = {quo[DATA_W-2:0], trial_ok};

  // --------------------------------------------------------------------------
  // Sign fix-up and result selection
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] quo_final;
  logic [DATA_W-1:0] rem_final;

  assign quo_final = div_zero ? {DATA_W{1'b1}}
                              : (quo_neg ? (~quo + 1'b1) : quo);
  assign rem_final = div_zero ? dividend
                              : (rem_neg ? (~rem + 1'b1) : rem);

  // --------------------------------------------------------------------------
  // Control and state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      dividend     <= '0;
      quo_neg      <= 1'b0;
      rem_neg      <= 1'b0;
      rem_sel      <= 1'b0;
      div_zero     <= 1'b0;
      count        <= '0;
      M_div_busy   <= 1'b0;
      M_div_done   <= 1'b0;
      M_div_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (E_div_start) begin
            divisor    <= src2_mag;
            dividend   <= E_src1;
            quo_neg    <= E_div_signed & (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
            rem_neg    <= src1_neg;
            rem_sel    <= E_div_rem;
            div_zero   <= (E_src2 == '0);
            count      <= 5'd31;
            M_div_busy <= 1'b1;
            if (early_out) begin
              quo   <= '0;
              rem   <= src1_mag;
              state <= FIX;
            end else begin
              quo   <= src1_mag;
              rem   <= '0;
              state <= RUN;
            end
          end
        end

        RUN: begin
          rem <= rem_step;
          quo <= quo_step;
          if (count == 5'd0) begin
            state <= FIX;
          end else begin
            count <= count - 5'd1;
          end
        end

        FIX: begin
          M_div_result <= rem_sel ? rem_final : quo_final;
          M_div_done   <= 1'b1;
          state        <= DONE;
        end

        DONE: begin
          // Any start seen here is dropped; only IDLE accepts work.
          M_div_done <= 1'b0;
          M_div_busy <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell
// Description : Scoreboard bench for the multi-cycle divider. The stimulus
//               thread queues the expected result and the due cycle for each
//               accepted operation. A monitor thread pops and compares on
//               every done pulse. Expected values come from plain integer
//               arithmetic.
// Options     : QSYS_NIOS2_DDR3_CPU_DIV_EARLY_OUT_EN changes the expected
//               latency of short operations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic        remsel = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  qsys_nios2_ddr3_nios2_qsys_0_cpu_div_cell #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .E_src1       (src1),
    .E_src2       (src2),
    .E_div_start  (start),
    .E_div_signed (sgn),
    .E_div_rem    (remsel),
    .M_div_busy   (busy),
    .M_div_done   (done),
    .M_div_result (result)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference: C-style truncating division, div-by-zero gives all ones / dividend.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic r);
    longint sa, sb, qq, rr;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (!s) return r ? (a % b) : (a / b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    return r ? rr[31:0] : qq[31:0];
  endfunction

  function automatic longint mag(input logic [31:0] v, input logic s);
    longint x;
    x = s ? longint'($signed(v)) : longint'({32'd0, v});
    return (x < 0) ? -x : x;
  endfunction

  function automatic int latency(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef QSYS_NIOS2_DDR3_CPU_DIV_EARLY_OUT_EN
    if (b == 32'd0 || mag(a, s) < mag(b, s)) return 2;
`endif
    return 34;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic r, input string tag);
    exp_t e;
    e.res = model(a, b, s, r);
    e.due = cycle + latency(a, b, s);
    e.tag = tag;
    sbq.push_back(e);
    src1 = a; src2 = b; sgn = s; remsel = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    // Operands are don't-care while busy.
    src1 = $urandom; src2 = $urandom; sgn = 1'($urandom); remsel = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !done) return;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    // Monitor: compare every done pulse against the head of the scoreboard.
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (reset_n && done) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: result %h at cycle %0d", result, cycle);
          end else begin
            e = sbq.pop_front();
            check(e.tag, result, e.res);
            check({e.tag, "_latency"}, 32'(cycle), 32'(e.due));
            check({e.tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    issue(32'd100, 32'd7, 1'b0, 1'b0, "u100_7_q");            wait_idle();
    check("idle_after_done", {31'd0, busy}, 32'd0);
    issue(32'd100, 32'd7, 1'b0, 1'b1, "u100_7_r");            wait_idle();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "s_m7_2_q");      wait_idle();
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, "s_m7_2_r");      wait_idle();
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "u_fff9_2_q");    wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b1, 1'b0, "s_div0_q");      wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b1, 1'b1, "s_div0_r");      wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b0, 1'b0, "u_div0_q");      wait_idle();
    issue(32'h1234_5678, 32'd0, 1'b0, 1'b1, "u_div0_r");      wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_ovf_q"); wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, "s_ovf_r"); wait_idle();
    issue(32'd5, 32'd9, 1'b0, 1'b1, "u5_9_r");                wait_idle();
    issue(32'd5, 32'd9, 1'b0, 1'b0, "u5_9_q");                wait_idle();
    issue(32'd9, 32'd5, 1'b0, 1'b0, "u9_5_q");                wait_idle();

    // Second start while busy is ignored; monitor flags any extra done.
    issue(32'd1000, 32'd3, 1'b0, 1'b0, "busy_first");
    repeat (3) @(negedge clk);
    src1 = 32'd77; src2 = 32'd1; sgn = 1'b0; remsel = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Start presented during the DONE cycle is ignored.
    issue(32'd50, 32'd6, 1'b0, 1'b0, "done_first");
    for (int i = 0; i < 60 && !done; i++) @(negedge clk);
    src1 = 32'd88; src2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts with no done pulse.
    issue(32'd12345, 32'd11, 1'b0, 1'b0, "aborted");
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    sbq.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(32'd3, 32'd1, 1'b0, 1'b0, "after_reset_3_1");       wait_idle();

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1: b = $urandom_range(0, 15);
        2: a = $urandom_range(0, 1000);
        default: b = a >> $urandom_range(0, 31);
      endcase
      issue(a, b, 1'($urandom), 1'($urandom), $sformatf("rand%0d", n));
      wait_idle();
    end

    // Drain
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
